pipe_hazard_ctrl: RTL and testbench

- Sequences the 5-stage datapath's front end.
- Turns the hazard detector's load_stall/br_stall into a timed IsStall window.
- Issues the one-cycle BHT/BTB update strobes after each branch/JAL resolves in ID.
- Keeps saturating branch and mispredict counters for bench and performance readout.
- Sits between the hazard detector and the datapath's IsStall/bht_update/btb_update/bht_update_dir inputs.

---
 rtl/pipe_hazard_ctrl.sv | 84 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer: turns load/branch hazards into a timed is_stall window and
// issues one-cycle BHT/BTB update strobes plus saturating perf counters per resolved branch.
module pipe_hazard_ctrl #(
    parameter int MAX_BR_STALL = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             start,
    input  logic             load_stall,
    input  logic [1:0]       br_stall,
    input  logic             id_is_branch,
    input  logic             id_pcsrc,
    input  logic             if_id_branch_pred,
    output logic             is_stall,
    output logic             bht_update,
    output logic             bht_update_dir,
    output logic             btb_update,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic             busy
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] MAX_BS = MAX_BR_STALL[1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic [1:0] stall_cnt;
    logic [1:0] br_clamp;
    logic [1:0] need;
    logic       resolve;

    always_comb begin
        br_clamp = (br_stall > MAX_BS) ? MAX_BS : br_stall;
        need     = (load_stall && br_clamp == 2'd0) ? 2'd1 : br_clamp;
    end

    // Gated by start so the freeze releases the instant reset is asserted.
    assign is_stall = !start && ((state == STALL) || (need != 2'd0));
    assign resolve  = (state == RUN) && !is_stall && id_is_branch;
    assign busy     = (state == STALL);

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state          <= RUN;
            stall_cnt      <= 2'd0;
            bht_update     <= 1'b0;
            bht_update_dir <= 1'b0;
            btb_update     <= 1'b0;
            mispredict     <= 1'b0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            bht_update     <= resolve;
            bht_update_dir <= resolve && id_pcsrc;
            btb_update     <= resolve && id_pcsrc;
            mispredict     <= resolve && (id_pcsrc != if_id_branch_pred);
            if (resolve) begin
                if (br_count != CNT_MAX)
                    br_count <= br_count + CNT_W'(1);
                if ((id_pcsrc != if_id_branch_pred) && (mispred_count != CNT_MAX))
                    mispred_count <= mispred_count + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    // A single-cycle stall stays in RUN so hazards are re-sampled next cycle.
                    if (need >= 2'd2) begin
                        state     <= STALL;
                        stall_cnt <= need - 2'd1;
                    end
                end
                STALL: begin
                    stall_cnt <= stall_cnt - 2'd1;
                    if (stall_cnt == 2'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle vector table plus reset-mid-stall
// and counter saturation sequences.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             start;
    logic             load_stall;
    logic [1:0]       br_stall;
    logic             id_is_branch;
    logic             id_pcsrc;
    logic             if_id_branch_pred;
    logic             is_stall;
    logic             bht_update;
    logic             bht_update_dir;
    logic             btb_update;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.MAX_BR_STALL(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .start(start), .load_stall(load_stall), .br_stall(br_stall),
        .id_is_branch(id_is_branch), .id_pcsrc(id_pcsrc),
        .if_id_branch_pred(if_id_branch_pred), .is_stall(is_stall),
        .bht_update(bht_update), .bht_update_dir(bht_update_dir),
        .btb_update(btb_update), .mispredict(mispredict), .br_count(br_count),
        .mispred_count(mispred_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs for one cycle; expected values are what is visible during that cycle
    // (registered outputs therefore reflect the previous row's inputs).
    typedef struct {
        logic       ls;
        logic [1:0] bs;
        logic       br, pc, pd;
        logic       st, bu, bht, dir, btb, mis;
        logic [3:0] brc, mc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ls, input logic [1:0] bs, input logic br,
                         input logic pc, input logic pd);
        load_stall = ls; br_stall = bs; id_is_branch = br;
        id_pcsrc = pc; if_id_branch_pred = pd;
    endtask

    initial begin
        //                ls  bs   br  pc  pd   st  bu  bht dir btb mis brc mc
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0});
        tbl.push_back('{1'b1,2'd0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0});
        tbl.push_back('{1'b0,2'd2,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0});
        tbl.push_back('{1'b0,2'd2,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0});
        tbl.push_back('{1'b0,2'd0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,4'd1,4'd1});
        tbl.push_back('{1'b0,2'd0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1,4'd1});
        tbl.push_back('{1'b0,2'd0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd2,4'd1});
        tbl.push_back('{1'b0,2'd0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'd3,4'd1});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,4'd4,4'd2});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b0,2'd3,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b0,2'd3,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b1,2'd2,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b1,2'd0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b0,2'd0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd4,4'd2});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,4'd5,4'd2});
        tbl.push_back('{1'b0,2'd1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd5,4'd2});
        tbl.push_back('{1'b0,2'd0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd5,4'd2});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,4'd6,4'd3});
        tbl.push_back('{1'b0,2'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd6,4'd3});

        // Reset: is_stall must stay low even with a hazard present.
        start = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_is_stall", 32'(is_stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bht", 32'(bht_update), 32'd0);
        check("rst_mis", 32'(mispredict), 32'd0);
        check("rst_brc", 32'(br_count), 32'd0);
        check("rst_mc", 32'(mispred_count), 32'd0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].ls, tbl[i].bs, tbl[i].br, tbl[i].pc, tbl[i].pd);
            #1;
            check($sformatf("row%0d is_stall", i), 32'(is_stall), 32'(tbl[i].st));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bu));
            check($sformatf("row%0d bht_update", i), 32'(bht_update), 32'(tbl[i].bht));
            check($sformatf("row%0d bht_dir", i), 32'(bht_update_dir), 32'(tbl[i].dir));
            check($sformatf("row%0d btb_update", i), 32'(btb_update), 32'(tbl[i].btb));
            check($sformatf("row%0d mispredict", i), 32'(mispredict), 32'(tbl[i].mis));
            check($sformatf("row%0d br_count", i), 32'(br_count), 32'(tbl[i].brc));
            check($sformatf("row%0d mispred_count", i), 32'(mispred_count), 32'(tbl[i].mc));
            @(posedge clk); #1;
        end

        // Reset in the middle of a branch stall.
        drive(1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
        #1;
        check("mid_first_stall", 32'(is_stall), 32'd1);
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'd1);
        #2 start = 1'b1;
        #1;
        check("mid_is_stall_drop", 32'(is_stall), 32'd0);
        check("mid_busy_drop", 32'(busy), 32'd0);
        check("mid_brc_clear", 32'(br_count), 32'd0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 start = 1'b0;
        @(posedge clk); #1;
        check("mid_no_bht1", 32'(bht_update), 32'd0);
        check("mid_busy_after", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("mid_no_bht2", 32'(bht_update), 32'd0);
        check("mid_brc_after", 32'(br_count), 32'd0);

        // Saturation: 20 back-to-back mispredicted branches.
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 13) begin
                check("sat_brc_14", 32'(br_count), 32'd14);
                check("sat_mc_14", 32'(mispred_count), 32'd14);
            end
        end
        check("sat_brc", 32'(br_count), 32'd15);
        check("sat_mc", 32'(mispred_count), 32'd15);
        check("sat_bht_pulse", 32'(bht_update), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("sat_brc_hold", 32'(br_count), 32'd15);
        check("sat_bht_end", 32'(bht_update), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
